// File: rtl/vidmem_resp.sv
// Frame-buffer memory responder: accepts read/write bursts from the bus, bids
// the arbiter, then returns read beats or a single write response.
module vidmem_resp #(
  parameter int         MEM_WORDS = 256,
  parameter logic [3:0] RSP_TAR   = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout
);

  localparam int IW = $clog2(MEM_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_BID  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_BID  = 3'd4;
  localparam logic [2:0] S_WR_RSP  = 3'd5;

  localparam logic [2:0] CMD_DATA  = 3'b000;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [2:0] CMD_WR    = 3'b100;
  localparam logic [2:0] CMD_RDAT  = 3'b011;
  localparam logic [2:0] CMD_WRSP  = 3'b101;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    len_q, len_d;
  logic [31:0]   addr_q, addr_d;

  logic [1:0]    reqout_q, reqout_d;
  logic [3:0]    reqtar_q, reqtar_d;
  logic [2:0]    cmdout_q, cmdout_d;
  logic [1:0]    lenout_q, lenout_d;
  logic [31:0]   addrdataout_q, addrdataout_d;

  logic          mem_we;
  logic [31:0]   mem [MEM_WORDS];

  function automatic logic [3:0] beats(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    addr_d        = addr_q;
    reqout_d      = 2'b00;
    reqtar_d      = 4'h0;
    cmdout_d      = 3'b000;
    lenout_d      = 2'b00;
    addrdataout_d = 32'h0;
    mem_we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (selin && (cmdin == CMD_RD || cmdin == CMD_WR)) begin
          idx_d  = addrdatain[IW+1:2];
          len_d  = lenin;
          addr_d = {addrdatain[31:2], 2'b00};
          cnt_d  = beats(lenin);
          if (cmdin == CMD_RD) begin
            state_d  = S_RD_BID;
            reqout_d = 2'b11;
            reqtar_d = RSP_TAR;
          end else begin
            state_d  = S_WR_DATA;
          end
        end
      end
      S_RD_BID, S_RD_DATA: begin
        // cnt_q holds beats still to be launched; the next beat is read here
        // so it appears on the registered output in the following cycle.
        if ((state_q == S_RD_BID && ackin) || (state_q == S_RD_DATA && cnt_q != 4'd0)) begin
          state_d       = S_RD_DATA;
          reqout_d      = 2'b11;
          reqtar_d      = RSP_TAR;
          cmdout_d      = CMD_RDAT;
          lenout_d      = len_q;
          addrdataout_d = mem[idx_q];
          idx_d         = idx_q + IW'(1);
          cnt_d         = cnt_q - 4'd1;
        end else if (state_q == S_RD_BID) begin
          reqout_d = 2'b11;
          reqtar_d = RSP_TAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (selin && cmdin == CMD_DATA) begin
          mem_we = 1'b1;
          idx_d  = idx_q + IW'(1);
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = S_WR_BID;
            reqout_d = 2'b11;
            reqtar_d = RSP_TAR;
          end
        end
      end
      S_WR_BID: begin
        reqout_d = 2'b11;
        reqtar_d = RSP_TAR;
        if (ackin) begin
          state_d       = S_WR_RSP;
          cmdout_d      = CMD_WRSP;
          lenout_d      = len_q;
          addrdataout_d = addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      reqout_q      <= 2'b00;
      reqtar_q      <= 4'h0;
      cmdout_q      <= 3'b000;
      lenout_q      <= 2'b00;
      addrdataout_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reqout_q      <= reqout_d;
      reqtar_q      <= reqtar_d;
      cmdout_q      <= cmdout_d;
      lenout_q      <= lenout_d;
      addrdataout_q <= addrdataout_d;
    end
  end

  // Captured request fields are only consumed after the state leaves IDLE,
  // so they need no reset.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    len_q  <= len_d;
    addr_q <= addr_d;
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx_q] <= addrdatain;
  end

  assign reqout      = reqout_q;
  assign reqtar      = reqtar_q;
  assign cmdout      = cmdout_q;
  assign lenout      = lenout_q;
  assign addrdataout = addrdataout_q;

endmodule

// File: tb/tb_vidmem_resp.sv
// Randomized bench for vidmem_resp: bus transactions are driven cycle by cycle
// and outputs are compared with a word-array model of the frame buffer.
module tb_vidmem_resp;

  localparam int         MW  = 256;
  localparam logic [3:0] TAR = 4'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mdl [MW];

  vidmem_resp #(.MEM_WORDS(MW), .RSP_TAR(TAR)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackin(ackin), .reqout(reqout), .reqtar(reqtar),
    .cmdout(cmdout), .lenout(lenout), .addrdataout(addrdataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = $urandom(); ackin = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".reqout"}, 32'(reqout), 32'd0);
    chk({tag, ".reqtar"}, 32'(reqtar), 32'd0);
    chk({tag, ".cmdout"}, 32'(cmdout), 32'd0);
    chk({tag, ".lenout"}, 32'(lenout), 32'd0);
    chk({tag, ".data"}, addrdataout, 32'd0);
  endtask

  task automatic bid(input string tag, input int ackdly);
    for (int d = 0; d <= ackdly; d++) begin
      chk({tag, ".bid_req"}, 32'(reqout), 32'd3);
      chk({tag, ".bid_tar"}, 32'(reqtar), 32'(TAR));
      chk({tag, ".bid_cmd"}, 32'(cmdout), 32'd0);
      ackin = (d == ackdly);
      tick();
    end
    ackin = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [1:0] len, input int stall_at,
                    input int ackdly, input bit seq, input logic [31:0] base);
    int n = 1 << len;
    int idx = int'(addr[9:2]);
    selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
    tick();
    for (int b = 0; b < n; b++) begin
      if (b == stall_at) begin
        bus_idle();
        tick();
        chk("wr.stall", 32'(reqout), 32'd0);
      end
      selin = 1'b1; cmdin = 3'b000; lenin = $urandom();
      addrdatain = seq ? base + 32'(b) : $urandom();
      mdl[(idx + b) % MW] = addrdatain;
      tick();
      chk("wr.beat_cmd", 32'(cmdout), 32'd0);
      chk("wr.beat_req", 32'(reqout), (b == n - 1) ? 32'd3 : 32'd0);
    end
    bus_idle();
    bid("wr", ackdly);
    chk("wr.rsp_cmd", 32'(cmdout), 32'b101);
    chk("wr.rsp_len", 32'(lenout), 32'(len));
    chk("wr.rsp_addr", addrdataout, addr & 32'hFFFF_FFFC);
    tick();
    chk_idle("wr.end");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [1:0] len, input int ackdly,
                    input bit inj, input int rst_beat);
    int n = 1 << len;
    int idx = int'(addr[9:2]);
    selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr;
    tick();
    bus_idle();
    bid("rd", ackdly);
    for (int b = 0; b < n; b++) begin
      chk("rd.cmd", 32'(cmdout), 32'b011);
      chk("rd.len", 32'(lenout), 32'(len));
      chk("rd.req", 32'(reqout), 32'd3);
      chk("rd.data", addrdataout, mdl[(idx + b) % MW]);
      if (inj && b == 0) begin
        selin = 1'b1; cmdin = 3'b100; lenin = 2'b00; addrdatain = addr;
      end else if (inj && b == 1) begin
        selin = 1'b1; cmdin = 3'b000; addrdatain = 32'hDEAD_BEEF;
      end else begin
        bus_idle();
      end
      if (b == rst_beat) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus_idle();
        chk_idle("rd.rst");
        return;
      end
      tick();
    end
    bus_idle();
    chk_idle("rd.end");
  endtask

  initial begin
    reset = 1'b0;
    bus_idle();
    repeat (3) tick();
    chk_idle("reset");
    // Request presented on the very edge that first sees reset released.
    reset = 1'b1;
    for (int k = 0; k < MW / 8; k++) wr(32'(k * 32), 2'b11, -1, 0, 1'b0, 32'h0);

    wr(32'h10, 2'b10, -1, 0, 1'b1, 32'hA0);
    rd(32'h10, 2'b10, 3, 1'b0, -1);
    chk("mem4", mdl[4], 32'hA0);
    chk("mem7", mdl[7], 32'hA3);
    rd(32'h3F8, 2'b10, 0, 1'b0, -1);
    rd(32'hFFFF_F3FB, 2'b11, 1, 1'b0, -1);
    rd(32'h40, 2'b10, 0, 1'b1, -1);
    rd(32'h40, 2'b10, 0, 1'b0, -1);
    wr(32'h80, 2'b10, 1, 2, 1'b0, 32'h0);
    rd(32'h7C, 2'b11, 0, 1'b0, -1);
    rd(32'h200, 2'b10, 0, 1'b0, 1);
    rd(32'h204, 2'b00, 0, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [1:0]  l;
      a = $urandom();
      l = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        wr(a, l, $urandom_range(0, 1) == 0 ? -1 : int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)), 1'b0, 32'h0);
      else
        rd(a, l, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
